// File: rtl/l2_cache_pkg.sv
// Shared L2 cache types: address field widths, line type, set count and FSM states.
// Geometry is fixed: 2 ways x 8 sets x 16-byte lines.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_l1_line;
    typedef logic [8:0]   lc3b_l2_tag;
    typedef logic [2:0]   lc3b_l2_index;

    localparam int unsigned L2_NUM_SETS = 8;
    localparam int unsigned L2_NUM_WAYS = 2;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        FILL
    } l2_state_e;

    function automatic lc3b_word l2_line_addr(lc3b_l2_tag tag, lc3b_l2_index idx);
        return {tag, idx, 4'b0000};
    endfunction

endpackage

// File: rtl/l2_cache_if.sv
// Bus bundles for the L2 cache: arbiter-facing request port and memory-facing port.
// "master" is the side that issues requests on each bus.
interface l2_arb_if;
    import lc3b_types::*;

    lc3b_word    l2cache_address;
    lc3b_l1_line l2cache_wdata;
    lc3b_l1_line l2cache_rdata;
    logic        l2_read;
    logic        l2_write;
    logic        l2_resp;

    modport master (
        output l2cache_address, l2cache_wdata, l2_read, l2_write,
        input  l2cache_rdata, l2_resp
    );

    modport slave (
        input  l2cache_address, l2cache_wdata, l2_read, l2_write,
        output l2cache_rdata, l2_resp
    );
endinterface

interface l2_pmem_if;
    import lc3b_types::*;

    lc3b_word    pmem_address;
    lc3b_l1_line pmem_wdata;
    lc3b_l1_line pmem_rdata;
    logic        pmem_read;
    logic        pmem_write;
    logic        pmem_resp;

    modport master (
        output pmem_address, pmem_wdata, pmem_read, pmem_write,
        input  pmem_rdata, pmem_resp
    );

    modport slave (
        input  pmem_address, pmem_wdata, pmem_read, pmem_write,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/l2_cache_way.sv
// One cache way: per-set data/tag storage with combinational read and clocked write.
// Only valid/dirty are cleared by reset; data and tags keep their contents.
module l2_way
    import lc3b_types::*;
(
    input  logic         clk,
    input  logic         reset,
    input  lc3b_l2_index idx_i,
    input  logic         load_i,
    input  lc3b_l2_tag   tag_i,
    input  lc3b_l1_line  data_i,
    input  logic         dirty_i,
    output lc3b_l2_tag   tag_o,
    output lc3b_l1_line  data_o,
    output logic         valid_o,
    output logic         dirty_o
);

    lc3b_l1_line                data_q [L2_NUM_SETS];
    lc3b_l2_tag                 tag_q  [L2_NUM_SETS];
    logic [L2_NUM_SETS-1:0]     valid_q;
    logic [L2_NUM_SETS-1:0]     dirty_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (load_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= dirty_i;
        end
    end

    always_ff @(posedge clk) begin
        if (load_i) begin
            data_q[idx_i] <= data_i;
            tag_q[idx_i]  <= tag_i;
        end
    end

    assign tag_o   = tag_q[idx_i];
    assign data_o  = data_q[idx_i];
    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];

endmodule

// File: rtl/l2_cache.sv
// 2-way set-associative write-back, write-allocate L2 cache with per-set LRU.
// Misses evict (writing back if dirty), fill, then re-enter LOOKUP to complete as a hit.
module l2_cache
    import lc3b_types::*;
(
    input  logic      clk,
    input  logic      reset,
    l2_arb_if.slave   arb,
    l2_pmem_if.master mem
);

    l2_state_e              state_q, state_d;
    lc3b_l2_tag             tag_q;
    lc3b_l2_index           idx_q;
    lc3b_l1_line            wdata_q;
    logic                   write_q;
    logic                   victim_q;
    logic [L2_NUM_SETS-1:0] lru_q;      // per set: index of the least recently used way

    lc3b_l2_tag  way_tag   [L2_NUM_WAYS];
    lc3b_l1_line way_data  [L2_NUM_WAYS];
    logic [1:0]  way_valid;
    logic [1:0]  way_dirty;
    logic [1:0]  way_hit;
    logic [1:0]  way_load;
    lc3b_l1_line line_in;
    logic        dirty_in;
    logic        hit;
    logic        hit_way;
    logic        victim;

    l2_way u_way0 (
        .clk     (clk),
        .reset   (reset),
        .idx_i   (idx_q),
        .load_i  (way_load[0]),
        .tag_i   (tag_q),
        .data_i  (line_in),
        .dirty_i (dirty_in),
        .tag_o   (way_tag[0]),
        .data_o  (way_data[0]),
        .valid_o (way_valid[0]),
        .dirty_o (way_dirty[0])
    );

    l2_way u_way1 (
        .clk     (clk),
        .reset   (reset),
        .idx_i   (idx_q),
        .load_i  (way_load[1]),
        .tag_i   (tag_q),
        .data_i  (line_in),
        .dirty_i (dirty_in),
        .tag_o   (way_tag[1]),
        .data_o  (way_data[1]),
        .valid_o (way_valid[1]),
        .dirty_o (way_dirty[1])
    );

    assign way_hit[0] = way_valid[0] && (way_tag[0] == tag_q);
    assign way_hit[1] = way_valid[1] && (way_tag[1] == tag_q);
    assign hit        = |way_hit;
    assign hit_way    = way_hit[1];

    always_comb begin
        if (!way_valid[0])      victim = 1'b0;
        else if (!way_valid[1]) victim = 1'b1;
        else                    victim = lru_q[idx_q];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (arb.l2_read || arb.l2_write) state_d = LOOKUP;
            LOOKUP: begin
                if (hit)                                         state_d = IDLE;
                else if (way_valid[victim] && way_dirty[victim]) state_d = WRITEBACK;
                else                                             state_d = FILL;
            end
            WRITEBACK: if (mem.pmem_resp) state_d = FILL;
            FILL:      if (mem.pmem_resp) state_d = LOOKUP;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        arb.l2_resp      = 1'b0;
        mem.pmem_read    = 1'b0;
        mem.pmem_write   = 1'b0;
        mem.pmem_address = l2_line_addr(tag_q, idx_q);
        way_load         = '0;
        line_in          = wdata_q;
        dirty_in         = 1'b1;
        unique case (state_q)
            LOOKUP: begin
                if (hit) begin
                    arb.l2_resp = 1'b1;
                    if (write_q) way_load[hit_way] = 1'b1;
                end
            end
            WRITEBACK: begin
                mem.pmem_write   = 1'b1;
                mem.pmem_address = l2_line_addr(way_tag[victim_q], idx_q);
            end
            FILL: begin
                mem.pmem_read = 1'b1;
                if (mem.pmem_resp) begin
                    way_load[victim_q] = 1'b1;
                    line_in            = mem.pmem_rdata;
                    dirty_in           = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign mem.pmem_wdata    = way_data[victim_q];
    assign arb.l2cache_rdata = way_data[hit_way];

    // A simultaneous read+write request is latched as a write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_q    <= '0;
            idx_q    <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            victim_q <= 1'b0;
            lru_q    <= '0;
        end else begin
            if (state_q == IDLE && (arb.l2_read || arb.l2_write)) begin
                tag_q   <= arb.l2cache_address[15:7];
                idx_q   <= arb.l2cache_address[6:4];
                wdata_q <= arb.l2cache_wdata;
                write_q <= arb.l2_write;
            end
            if (state_q == LOOKUP) begin
                if (hit) lru_q[idx_q] <= ~hit_way;
                else     victim_q     <= victim;
            end
        end
    end

endmodule
